// File: rtl/exec_stage.sv
// Execute stage: 64-bit ALU (add/sub/and/xor) with a one-entry registered output,
// valid/ready handshakes on both sides and a count of results taken downstream.
// Optional condition-code register compiled in with `define EXEC_STAGE_CC_EN.
module exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic [CNT_W-1:0] op_count
);

  logic             r_valid;
  logic [63:0]      r_result;
  logic             r_of;
  logic [CNT_W-1:0] r_count;

  logic        w_accept;
  logic        w_hs;
  logic [63:0] w_alu_res;
  logic        w_alu_of;

  // Output register is free, or is being drained this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_hs     = r_valid && out_ready;

  // ALU: result and signed overflow (overflow is only meaningful for add/sub).
  always_comb begin
    w_alu_res = '0;
    w_alu_of  = 1'b0;
    unique case (in_opcode)
      2'b00: begin
        w_alu_res = in_a + in_b;
        w_alu_of  = (in_a[63] == in_b[63]) && (w_alu_res[63] != in_a[63]);
      end
      2'b01: begin
        w_alu_res = in_a - in_b;
        w_alu_of  = (in_a[63] != in_b[63]) && (w_alu_res[63] != in_a[63]);
      end
      2'b10:   w_alu_res = in_a & in_b;
      default: w_alu_res = in_a ^ in_b;
    endcase
  end

  // Output register: load on accept, drop valid when drained without a replacement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_of     <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_alu_res;
      r_of     <= w_alu_of;
    end else if (w_hs) begin
      r_valid  <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_hs) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_of     = r_of;
  assign op_count   = r_count;

`ifdef EXEC_STAGE_CC_EN
  logic r_cc_zf;
  logic r_cc_sf;
  logic r_cc_of;

  // Condition codes follow accepted operations that request them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cc_zf <= 1'b0;
      r_cc_sf <= 1'b0;
      r_cc_of <= 1'b0;
    end else if (w_accept && in_set_cc) begin
      r_cc_zf <= (w_alu_res == 64'd0);
      r_cc_sf <= w_alu_res[63];
      r_cc_of <= w_alu_of;
    end
  end

  assign cc_zf = r_cc_zf;
  assign cc_sf = r_cc_sf;
  assign cc_of = r_cc_of;
`else
  logic w_unused_set_cc;
  assign w_unused_set_cc = in_set_cc;
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: a default-width instance plus a CNT_W=4 instance
// sharing the same stimulus (the narrow one exercises counter wrap).
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_opcode;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_set_cc;
  logic        out_ready;

  logic        in_ready, out_valid, out_of, cc_zf, cc_sf, cc_of;
  logic [63:0] out_result;
  logic [15:0] op_count;

  logic        in_ready_4, out_valid_4, out_of_4, cc_zf_4, cc_sf_4, cc_of_4;
  logic [63:0] out_result_4;
  logic [3:0]  op_count_4;

  int n_pass  = 0;
  int n_total = 0;

`ifdef EXEC_STAGE_CC_EN
  localparam logic CC = 1'b1;
`else
  localparam logic CC = 1'b0;
`endif

  exec_stage #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_of(out_of), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .op_count(op_count)
  );

  exec_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_result(out_result_4),
    .out_of(out_of_4), .cc_zf(cc_zf_4), .cc_sf(cc_sf_4), .cc_of(cc_of_4),
    .op_count(op_count_4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic cc);
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_set_cc = cc;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_count", op_count, 0);
    check("rst_zf", cc_zf, 0);
    #11 reset = 1'b0;

    // add 5+7 with cc update
    drive(1'b1, 2'b00, 64'd5, 64'd7, 1'b1);
    out_ready = 1'b1;
    tick();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 64'd12);
    check("add_of", out_of, 0);
    check("add_zf", cc_zf, 0);
    check("add_sf", cc_sf, 0);
    check("add_ccof", cc_of, 0);
    check("add_count0", op_count, 0);
    drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    tick();
    check("add_count1", op_count, 1);
    check("add_drained", out_valid, 0);

    // sub MIN - 1 overflows
    drive(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    tick();
    check("sub_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_of", out_of, 1);
    check("sub_ccof", cc_of, CC);
    check("sub_sf", cc_sf, 0);

    // xor to zero, then back-to-back and with set_cc=0
    drive(1'b1, 2'b11, 64'h1234, 64'h1234, 1'b1);
    tick();
    check("xor_result", out_result, 0);
    check("xor_zf", cc_zf, CC);
    check("xor_of", out_of, 0);
    check("xor_ccof", cc_of, 0);
    check("xor_count", op_count, 2);
    drive(1'b1, 2'b10, 64'hF0, 64'h0F, 1'b0);
    tick();
    check("and_result", out_result, 0);
    check("and_valid", out_valid, 1);
    check("and_zf_kept", cc_zf, CC);
    check("and_of", out_of, 0);
    check("and_count", op_count, 3);
    drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    tick();
    check("and_count2", op_count, 4);

    // stall: result held while out_ready=0, pending op not accepted
    drive(1'b1, 2'b00, 64'd100, 64'd1, 1'b0);
    out_ready = 1'b0;
    tick();
    check("stall_result0", out_result, 64'd101);
    drive(1'b1, 2'b00, 64'd1, 64'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_result", out_result, 64'd101);
      check("stall_valid", out_valid, 1);
      check("stall_count", op_count, 4);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    tick();
    check("unstall_result", out_result, 64'd2);
    check("unstall_count", op_count, 5);

    // full-throughput stream
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'b00, 64'(i * 3), 64'd10, 1'b0);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_result", out_result, 64'(i * 3 + 10));
      check("stream_count", op_count, 64'(5 + i));
    end

    // positive add overflow sets sign and overflow
    drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    check("addov_result", out_result, 64'h8000_0000_0000_0000);
    check("addov_of", out_of, 1);
    check("addov_sf", cc_sf, CC);
    check("addov_ccof", cc_of, CC);
    check("addov_zf", cc_zf, 0);

    // asynchronous reset with a held result
    drive(1'b1, 2'b00, 64'd3, 64'd4, 1'b1);
    tick();
    check("pre_rst_result", out_result, 64'd7);
    drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_result", out_result, 0);
    check("arst_of", out_of, 0);
    check("arst_sf", cc_sf, 0);
    check("arst_ccof", cc_of, 0);
    check("arst_count", op_count, 0);
    check("arst_count4", op_count_4, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_count", op_count, 0);
    check("post_rst_valid", out_valid, 0);

    // 17 handshakes: narrow counter wraps to 1
    drive(1'b1, 2'b00, 64'd1, 64'd1, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    tick();
    check("wrap_count16", op_count, 17);
    check("wrap_count4", op_count_4, 1);
    tick();
    check("idle_ready_ignored", op_count, 17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of the completed-operation counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream (decode) presents an operation.
REQ-005 Port: in_ready  output  1  stage can accept an operation this cycle.
REQ-006 Port: in_opcode  input  2  00 add, 01 sub (in_a-in_b), 10 and, 11 xor.
REQ-007 Port: in_a  input  64  signed operand 1.
REQ-008 Port: in_b  input  64  signed operand 2.
REQ-009 Port: in_set_cc  input  1  operation updates condition codes.
REQ-010 Port: out_valid  output  1  registered result held for downstream (memory/writeback).
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_result  output  64  registered signed ALU result.
REQ-013 Port: out_of  output  1  registered overflow of that result.
REQ-014 Port: cc_zf, cc_sf, cc_of  output  1 each  condition-code register.
REQ-015 Port: op_count  output  CNT_W  count of results accepted downstream.

Function
REQ-016 The stage SHALL compute the result combinationally through the existing 64-bit alu (opcode mapping per REQ-006) and register it; latency from accept to out_valid SHALL be exactly 1 cycle.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), allowing one accept per cycle at full throughput.
REQ-018 An accept occurs when in_valid && in_ready; on accept out_result, out_of SHALL load the ALU outputs and out_valid SHALL be 1 next cycle.
REQ-019 Downstream handshake occurs when out_valid && out_ready; with no simultaneous accept, out_valid SHALL clear next cycle.
REQ-020 Simultaneous handshake and accept SHALL replace the held result with the new one, out_valid staying 1 (no bubble).
REQ-021 While out_valid && !out_ready, out_result and out_of SHALL remain stable and no accept SHALL occur.
REQ-022 out_of SHALL be two's-complement signed overflow for add/sub and 0 for and/xor.
REQ-023 op_count SHALL increment by 1 on each downstream handshake, wrapping from 2^CNT_W-1 to 0.
REQ-024 Inputs SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-025 On reset assertion, out_valid, out_result, out_of, cc_zf, cc_sf, cc_of, op_count SHALL go to 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard the held result; no handshake SHALL be reported for it and op_count SHALL not count it.
REQ-027 in_ready SHALL be 1 during and after reset.

Configuration
REQ-028 Macro EXEC_STAGE_CC_EN SHALL compile in the condition-code register.
REQ-029 With EXEC_STAGE_CC_EN defined, on an accept with in_set_cc=1, cc_zf SHALL load (result==0), cc_sf load result[63], cc_of load the overflow, visible the cycle after accept; accepts with in_set_cc=0 SHALL leave them unchanged.
REQ-030 Without EXEC_STAGE_CC_EN, cc_zf, cc_sf, cc_of SHALL be constant 0 and in_set_cc ignored; all other behaviour identical.

Verification
REQ-031 Add 5+7, set_cc=1, out_ready=1 -> next cycle out_valid=1, out_result=12, out_of=0, zf=0 sf=0 of=0; op_count=1 after handshake.
REQ-032 Sub 0x8000000000000000-1 -> out_result=0x7FFFFFFFFFFFFFFF, out_of=1, cc_of=1 (CC_EN) / 0 (no CC_EN).
REQ-033 Xor 0x1234 with 0x1234, set_cc=1 -> out_result=0, zf=1; following and 0xF0&0x0F with set_cc=0 -> result 0, zf stays 1, out_of=0.
REQ-034 out_ready=0 for 3 cycles after a result -> in_ready=0, out_result stable; back-to-back stream at out_ready=1 -> one result per cycle, no bubbles.
REQ-035 Reset asserted between clock edges with out_valid=1 -> all outputs 0 immediately, op_count=0, in_ready=1.
REQ-036 CNT_W=4, 17 handshakes -> op_count=1.
